// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order commit queue with writeback bypass and branch flush.
module reorder_buffer #(
  parameter int ROB_ADDR = 3
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  output logic                full,
  output logic [ROB_ADDR-1:0] issue_index,
  input  logic                issue_valid,
  input  logic [1:0]          issue_type,
  input  logic [4:0]          issue_rd,
  input  logic [31:0]         issue_pc,
  input  logic                issue_pred,
  input  logic                issue_ready,
  input  logic [31:0]         issue_value,
  input  logic                wb_valid,
  input  logic [ROB_ADDR-1:0] wb_index,
  input  logic [31:0]         wb_value,
  input  logic                wb_taken,
  input  logic [31:0]         wb_target,
  input  logic                lsb_valid,
  input  logic [ROB_ADDR-1:0] lsb_index,
  input  logic [31:0]         lsb_value,
  input  logic [ROB_ADDR-1:0] qry1_index,
  input  logic [ROB_ADDR-1:0] qry2_index,
  output logic                qry1_ready,
  output logic                qry2_ready,
  output logic [31:0]         qry1_value,
  output logic [31:0]         qry2_value,
  output logic                commit_valid,
  output logic [ROB_ADDR-1:0] commit_index,
  output logic [4:0]          commit_rd,
  output logic [31:0]         commit_value,
  output logic                commit_store,
  output logic                clear_out,
  output logic [31:0]         redirect_pc
);
  localparam int DEPTH = 1 << ROB_ADDR;
  localparam logic [1:0] T_STORE = 2'd1;
  localparam logic [1:0] T_BRANCH = 2'd2;

  logic [DEPTH-1:0]    busy_q, busy_d, ready_q, ready_d;
  logic [1:0]          type_q   [DEPTH];
  logic [4:0]          rd_q     [DEPTH];
  logic [31:0]         value_q  [DEPTH];
  logic [31:0]         pc_q     [DEPTH];
  logic [31:0]         target_q [DEPTH];
  logic [DEPTH-1:0]    pred_q, taken_q;
  logic [ROB_ADDR-1:0] head_q, head_d, tail_q, tail_d;
  logic [ROB_ADDR:0]   count_q, count_d;
  logic                do_issue, do_commit, mispred, lsb_hit;

  assign full        = count_q == (ROB_ADDR+1)'(DEPTH);
  assign issue_index = tail_q;
  assign do_issue    = issue_valid && !full;
  assign do_commit   = busy_q[head_q] && ready_q[head_q];
  assign mispred     = do_commit && type_q[head_q] == T_BRANCH && taken_q[head_q] != pred_q[head_q];
  assign lsb_hit     = lsb_valid && busy_q[lsb_index] && !(wb_valid && wb_index == lsb_index);
  assign head_d      = head_q + ROB_ADDR'(do_commit);
  assign tail_d      = tail_q + ROB_ADDR'(do_issue);
  assign count_d     = count_q + (ROB_ADDR+1)'(do_issue) - (ROB_ADDR+1)'(do_commit);

  // Operand lookups see this cycle's writebacks; ALU port takes priority over LSB.
  assign qry1_ready = busy_q[qry1_index] && (ready_q[qry1_index] ||
                      (wb_valid && wb_index == qry1_index) || (lsb_valid && lsb_index == qry1_index));
  assign qry2_ready = busy_q[qry2_index] && (ready_q[qry2_index] ||
                      (wb_valid && wb_index == qry2_index) || (lsb_valid && lsb_index == qry2_index));
  assign qry1_value = !busy_q[qry1_index] ? 32'd0 :
                      (wb_valid && wb_index == qry1_index) ? wb_value :
                      (lsb_valid && lsb_index == qry1_index) ? lsb_value : value_q[qry1_index];
  assign qry2_value = !busy_q[qry2_index] ? 32'd0 :
                      (wb_valid && wb_index == qry2_index) ? wb_value :
                      (lsb_valid && lsb_index == qry2_index) ? lsb_value : value_q[qry2_index];

  always_comb begin
    busy_d  = busy_q;
    ready_d = ready_q;
    if (wb_valid && busy_q[wb_index]) ready_d[wb_index] = 1'b1;
    if (lsb_valid && busy_q[lsb_index]) ready_d[lsb_index] = 1'b1;
    if (do_commit) begin
      busy_d[head_q]  = 1'b0;
      ready_d[head_q] = 1'b0;
    end
    if (do_issue) begin
      busy_d[tail_q]  = 1'b1;
      ready_d[tail_q] = issue_ready;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy_q       <= '0;
      ready_q      <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      commit_valid <= 1'b0;
      commit_index <= '0;
      commit_rd    <= '0;
      commit_value <= '0;
      commit_store <= 1'b0;
      clear_out    <= 1'b0;
      redirect_pc  <= '0;
    end else if (rdy_in) begin
      commit_valid <= do_commit;
      clear_out    <= mispred;
      if (do_commit) begin
        commit_index <= head_q;
        commit_rd    <= (type_q[head_q] == T_STORE || type_q[head_q] == T_BRANCH) ? 5'd0 : rd_q[head_q];
        commit_value <= value_q[head_q];
        commit_store <= type_q[head_q] == T_STORE;
      end
      if (mispred) redirect_pc <= taken_q[head_q] ? target_q[head_q] : pc_q[head_q] + 32'd4;
      busy_q  <= mispred ? '0 : busy_d;
      ready_q <= mispred ? '0 : ready_d;
      head_q  <= mispred ? '0 : head_d;
      tail_q  <= mispred ? '0 : tail_d;
      count_q <= mispred ? '0 : count_d;
    end else begin
      commit_valid <= 1'b0;
      clear_out    <= 1'b0;
    end
  end

  // Payload needs no reset: it is only observed through busy/ready.
  always_ff @(posedge clk_in) begin
    if (rdy_in) begin
      if (wb_valid && busy_q[wb_index]) begin
        value_q[wb_index]  <= wb_value;
        taken_q[wb_index]  <= wb_taken;
        target_q[wb_index] <= wb_target;
      end
      if (lsb_hit) value_q[lsb_index] <= lsb_value;
      if (do_issue) begin
        type_q[tail_q]   <= issue_type;
        rd_q[tail_q]     <= issue_rd;
        pc_q[tail_q]     <= issue_pc;
        pred_q[tail_q]   <= issue_pred;
        taken_q[tail_q]  <= 1'b0;
        target_q[tail_q] <= '0;
        value_q[tail_q]  <= issue_value;
      end
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: randomized stimulus against a queue-based reference model of the RoB.
module tb_reorder_buffer;
  logic        clk_in = 1'b0, rst_in = 1'b0, rdy_in = 1'b0;
  logic        full;
  logic [2:0]  issue_index;
  logic        issue_valid = 1'b0, issue_pred = 1'b0, issue_ready = 1'b0;
  logic [1:0]  issue_type = '0;
  logic [4:0]  issue_rd = '0;
  logic [31:0] issue_pc = '0, issue_value = '0;
  logic        wb_valid = 1'b0, wb_taken = 1'b0, lsb_valid = 1'b0;
  logic [2:0]  wb_index = '0, lsb_index = '0, qry1_index = '0, qry2_index = '0;
  logic [31:0] wb_value = '0, wb_target = '0, lsb_value = '0;
  logic        qry1_ready, qry2_ready, commit_valid, commit_store, clear_out;
  logic [31:0] qry1_value, qry2_value, commit_value, redirect_pc;
  logic [2:0]  commit_index;
  logic [4:0]  commit_rd;

  reorder_buffer #(.ROB_ADDR(3)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .full(full), .issue_index(issue_index),
    .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd(issue_rd), .issue_pc(issue_pc),
    .issue_pred(issue_pred), .issue_ready(issue_ready), .issue_value(issue_value),
    .wb_valid(wb_valid), .wb_index(wb_index), .wb_value(wb_value), .wb_taken(wb_taken),
    .wb_target(wb_target), .lsb_valid(lsb_valid), .lsb_index(lsb_index), .lsb_value(lsb_value),
    .qry1_index(qry1_index), .qry2_index(qry2_index), .qry1_ready(qry1_ready), .qry2_ready(qry2_ready),
    .qry1_value(qry1_value), .qry2_value(qry2_value), .commit_valid(commit_valid),
    .commit_index(commit_index), .commit_rd(commit_rd), .commit_value(commit_value),
    .commit_store(commit_store), .clear_out(clear_out), .redirect_pc(redirect_pc)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int        idx;
    bit        rdy;
    bit [1:0]  ty;
    bit [4:0]  rd;
    bit [31:0] val;
    bit [31:0] pc;
    bit        pred;
    bit        taken;
    bit [31:0] tgt;
  } ent_t;

  ent_t q[$];
  int   mtail = 0;
  int   n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] pick_idx();
    if (q.size() > 0 && $urandom_range(0, 4) != 0) return 3'(q[$urandom_range(0, q.size() - 1)].idx);
    return 3'($urandom_range(0, 7));
  endfunction

  task automatic drive(input int cyc);
    int  t;
    bit  nowb;
    nowb = (cyc % 200) < 40;
    rdy_in = $urandom_range(0, 19) != 0;
    issue_valid = $urandom_range(0, 2) != 0;
    t = $urandom_range(0, 9);
    issue_type = t < 6 ? 2'd0 : t < 8 ? 2'd1 : t == 8 ? 2'd2 : 2'd3;
    issue_rd = 5'($urandom);
    issue_pc = $urandom & 32'hFFFF_FFFC;
    issue_pred = 1'($urandom);
    issue_ready = $urandom_range(0, 3) == 0;
    issue_value = $urandom;
    wb_valid = !nowb && $urandom_range(0, 1) == 1;
    wb_index = pick_idx();
    wb_value = $urandom;
    wb_taken = 1'($urandom);
    wb_target = $urandom & 32'hFFFF_FFFC;
    lsb_valid = !nowb && $urandom_range(0, 2) == 0;
    lsb_index = $urandom_range(0, 7) == 0 ? wb_index : pick_idx();
    lsb_value = $urandom;
    qry1_index = $urandom_range(0, 3) == 0 ? wb_index : pick_idx();
    qry2_index = $urandom_range(0, 3) == 0 ? lsb_index : pick_idx();
  endtask

  task automatic check_comb();
    int i;
    bit r;
    bit [31:0] v;
    chk("full", full, q.size() == 8);
    chk("issue_index", issue_index, mtail);
    for (int k = 0; k < 2; k++) begin
      logic [2:0] qi;
      qi = k == 0 ? qry1_index : qry2_index;
      i = -1;
      foreach (q[j]) if (q[j].idx == qi) i = j;
      r = 0;
      v = 0;
      if (i >= 0) begin
        r = q[i].rdy;
        v = q[i].val;
        if (lsb_valid && lsb_index == qi) begin r = 1; v = lsb_value; end
        if (wb_valid && wb_index == qi) begin r = 1; v = wb_value; end
      end
      chk(k == 0 ? "qry1_ready" : "qry2_ready", k == 0 ? qry1_ready : qry2_ready, r);
      chk(k == 0 ? "qry1_value" : "qry2_value", k == 0 ? qry1_value : qry2_value, v);
    end
  endtask

  task automatic step_and_check();
    bit   e_cv = 0, e_clr = 0, com;
    int   sz;
    ent_t h, n;
    if (rdy_in) begin
      sz = q.size();
      com = sz > 0 && q[0].rdy;
      if (com) h = q[0];
      foreach (q[i]) begin
        if (lsb_valid && q[i].idx == lsb_index) begin q[i].rdy = 1; q[i].val = lsb_value; end
        if (wb_valid && q[i].idx == wb_index) begin
          q[i].rdy = 1; q[i].val = wb_value; q[i].taken = wb_taken; q[i].tgt = wb_target;
        end
      end
      if (com) begin
        void'(q.pop_front());
        e_cv = 1;
        if (h.ty == 2 && h.taken != h.pred) begin
          e_clr = 1;
          q.delete();
          mtail = 0;
        end
      end
      if (!e_clr && issue_valid && sz < 8) begin
        n.idx = mtail; n.rdy = issue_ready; n.ty = issue_type; n.rd = issue_rd; n.val = issue_value;
        n.pc = issue_pc; n.pred = issue_pred; n.taken = 0; n.tgt = 0;
        q.push_back(n);
        mtail = (mtail + 1) % 8;
      end
    end
    #1;
    chk("commit_valid", commit_valid, e_cv);
    chk("clear_out", clear_out, e_clr);
    if (e_cv) begin
      chk("commit_index", commit_index, h.idx);
      chk("commit_rd", commit_rd, (h.ty == 1 || h.ty == 2) ? 5'd0 : h.rd);
      chk("commit_value", commit_value, h.val);
      chk("commit_store", commit_store, h.ty == 1);
    end
    if (e_clr) chk("redirect_pc", redirect_pc, h.taken ? h.tgt : h.pc + 32'd4);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_commit_valid"}, commit_valid, 0);
    chk({tag, "_clear_out"}, clear_out, 0);
    chk({tag, "_commit_value"}, commit_value, 0);
    chk({tag, "_commit_rd"}, commit_rd, 0);
    chk({tag, "_redirect_pc"}, redirect_pc, 0);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_issue_index"}, issue_index, 0);
  endtask

  initial begin
    #12;
    check_zero("reset");
    @(negedge clk_in);
    rst_in = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk_in);
      if ($urandom_range(0, 299) == 0) begin
        rst_in = 1'b0;
        #1;
        check_zero("async_reset");
        q.delete();
        mtail = 0;
        @(negedge clk_in);
        rst_in = 1'b1;
      end
      drive(c);
      #1;
      check_comb();
      @(posedge clk_in);
      step_and_check();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
